load_data_register: RTL

- Parametrised successor to the plain memory data register in the multicycle datapath.
- Waits for a memory read response after a load request and captures the returned word.
- Performs load-type lane extraction with sign/zero extension and holds the result for the writeback stage.
- Sits between the memory interface and the register-file write mux.
- Adds a request/response handshake, an optional timeout and an optional misalignment check.

---
 rtl/load_data_register_if.sv | 27 ++
 rtl/load_data_register.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/load_data_register_if.sv
// Load request / memory response bundle for load_data_register.
// The master side issues loads and plays the memory; the slave side is the register.
interface load_data_register_if #(
    parameter int XLEN = 32
);
    localparam int OFS_W = $clog2(XLEN / 8);

    logic             req;
    logic [2:0]       funct3;
    logic [OFS_W-1:0] addr_lo;
    logic             mem_valid;
    logic [XLEN-1:0]  mem_rdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [XLEN-1:0]  dataOut;

    modport master (
        output req, funct3, addr_lo, mem_valid, mem_rdata,
        input  busy, done, err, dataOut
    );

    modport slave (
        input  req, funct3, addr_lo, mem_valid, mem_rdata,
        output busy, done, err, dataOut
    );
endinterface

// File: rtl/load_data_register.sv
// Memory data register with load-type lane extraction, request/response handshake and timeout.
// Optional misalignment check enabled by defining LDR_MISALIGN_EN.
module load_data_register #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input logic                  CLK,
    input logic                  RST,
    load_data_register_if.slave  bus
);
    localparam int OFS_W = $clog2(XLEN / 8);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       funct3_reg;
    logic [OFS_W-1:0] addr_lo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg, err_next;
    logic [XLEN-1:0]  data_reg, data_next;
    logic             accept;
    logic             timed_out;
    logic             busy_o, done_o, err_o;

    // Access size as log2(bytes); codes wider than the datapath become full-width loads.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        logic [1:0] s;
        s = f3[1:0];
        if (XLEN == 32 && s == 2'd3) s = 2'd2;
        return s;
    endfunction

    assign accept    = bus.req && (state_reg != S_WAIT);
    assign timed_out = (TIMEOUT > 0) && (cnt_reg == TO_LAST);

    // Lane extraction from the latched load type and offset.
    logic [1:0]       cap_size;
    logic [OFS_W-1:0] lane_mask, lane_off;
    logic [XLEN-1:0]  shifted, word_ext, extracted;
    logic             sgn;

    assign cap_size  = size_of(funct3_reg);
    assign lane_mask = OFS_W'((1 << cap_size) - 1);
    assign lane_off  = addr_lo_reg & ~lane_mask;
    assign shifted   = bus.mem_rdata >> {lane_off, 3'b000};
    assign sgn       = ~funct3_reg[2];

    generate
        if (XLEN == 64) begin : g_word
            assign word_ext = {{32{sgn & shifted[31]}}, shifted[31:0]};
        end else begin : g_word
            assign word_ext = shifted;
        end
    endgenerate

    always_comb begin
        extracted = shifted;
        case (cap_size)
            2'd0:    extracted = {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]};
            2'd1:    extracted = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};
            2'd2:    extracted = word_ext;
            default: extracted = shifted;
        endcase
    end

`ifdef LDR_MISALIGN_EN
    logic [1:0]       req_size;
    logic [OFS_W-1:0] req_mask;
    logic             misaligned;

    assign req_size   = size_of(bus.funct3);
    assign req_mask   = OFS_W'((1 << req_size) - 1);
    assign misaligned = |(bus.addr_lo & req_mask);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
            err_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            data_reg  <= data_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            funct3_reg  <= '0;
            addr_lo_reg <= '0;
            cnt_reg     <= '0;
        end else if (accept) begin
            funct3_reg  <= bus.funct3;
            addr_lo_reg <= bus.addr_lo;
            cnt_reg     <= '0;
        end else if (state_reg == S_WAIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        data_next  = data_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                err_next   = 1'b0;
                if (bus.req) begin
`ifdef LDR_MISALIGN_EN
                    if (misaligned) begin
                        state_next = S_DONE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
`else
                    state_next = S_WAIT;
`endif
                end
            end
            S_WAIT: begin
                // Data arriving on the timeout cycle still counts as a success.
                if (bus.mem_valid) begin
                    data_next  = extracted;
                    state_next = S_DONE;
                    err_next   = 1'b0;
                end else if (timed_out) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                err_next   = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy_o = (state_reg == S_WAIT);
        done_o = (state_reg == S_DONE);
        err_o  = (state_reg == S_DONE) && err_reg;
    end

    assign bus.busy    = busy_o;
    assign bus.done    = done_o;
    assign bus.err     = err_o;
    assign bus.dataOut = data_reg;
endmodule
